// File: rtl/calc_exec_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_exec_if
// Brief    : Operand/button inputs and LED/status outputs of the calculator
//            execution stage, with master (stimulus) and slave (stage) views.
// Revision : 1.0 - initial release
// ============================================================================
interface calc_exec_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       alu_op_n;
    logic [WIDTH-1:0] sw;
    logic             btnd;
    logic             btnu;
    logic [WIDTH-1:0] led;
    logic             ovf;
    logic             op_err;
    logic             done;
    logic             busy;

    modport master (
        output alu_op_n, sw, btnd, btnu,
        input  led, ovf, op_err, done, busy
    );

    modport slave (
        input  alu_op_n, sw, btnd, btnu,
        output led, ovf, op_err, done, busy
    );
endinterface

`default_nettype wire

// File: rtl/calc_exec_fsm.sv
`default_nettype none
// ============================================================================
// Module   : calc_exec_fsm
// Brief    : Calculator execution stage: synchronises btnd/btnu, applies the
//            latched opcode to a signed accumulator, drives LEDs and flags.
//            Optional button debounce filter: define CALC_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module calc_exec_fsm #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,        // must be >= 2
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    calc_exec_if.slave bus
);

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_SLT  = 4'b0111;
    localparam logic [3:0] c_OP_XOR  = 4'b1001;
    localparam logic [3:0] c_OP_NOR  = 4'b1010;
    localparam logic [3:0] c_OP_NAND = 4'b1101;

    localparam int c_MSB = WIDTH - 1;

`ifdef CALC_DEBOUNCE_EN
    localparam int c_DB_EN = 1;
`else
    localparam int c_DB_EN = 0;
`endif

    // Cycles after reset until the filtered button levels reflect the real pins
    localparam int c_SETTLE = SYNC_STAGES + c_DB_EN * DEBOUNCE_CYCLES;
    localparam int c_SET_W  = $clog2(c_SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LATCH    = 2'd1,
        S_EXEC     = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_btnd_sync;
    logic [SYNC_STAGES-1:0] r_btnu_sync;
    logic                   w_btnd_s;
    logic                   w_btnu_s;
    logic [1:0]             w_sync_lvl;
    logic [1:0]             w_filt;
    logic                   w_btnd_f;
    logic                   w_btnu_f;

    logic [c_SET_W-1:0]     r_settle_cnt;
    logic                   r_settled;

    state_t                 r_state;
    logic [3:0]             r_op_q;
    logic [WIDTH-1:0]       r_b_q;
    logic [WIDTH-1:0]       r_acc;
    logic                   r_ovf;
    logic                   r_op_err;
    logic                   r_done;
    logic                   r_busy;
    logic                   r_btnu_d;

    logic [WIDTH-1:0]       w_sum;
    logic [WIDTH-1:0]       w_diff;
    logic [WIDTH-1:0]       w_result;
    logic                   w_ovf;
    logic                   w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btnd_sync <= '0;
            r_btnu_sync <= '0;
        end else begin
            r_btnd_sync <= {r_btnd_sync[SYNC_STAGES-2:0], bus.btnd};
            r_btnu_sync <= {r_btnu_sync[SYNC_STAGES-2:0], bus.btnu};
        end
    end

    assign w_btnd_s   = r_btnd_sync[SYNC_STAGES-1];
    assign w_btnu_s   = r_btnu_sync[SYNC_STAGES-1];
    assign w_sync_lvl = {w_btnu_s, w_btnd_s};

`ifdef CALC_DEBOUNCE_EN
    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic [c_DB_W-1:0] r_cnt;
        logic              r_lvl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (w_sync_lvl[gi] != r_lvl) begin
                if (r_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_lvl <= w_sync_lvl[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_filt[gi] = r_lvl;
    end
`else
    assign w_filt = w_sync_lvl;
`endif

    assign w_btnd_f = w_filt[0];
    assign w_btnu_f = w_filt[1];

    // Hold WAIT_REL until the synchroniser/filter has been flushed, so a
    // button held across reset release is seen as still pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_settled    <= 1'b0;
        end else if (!r_settled) begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
            if (r_settle_cnt == c_SET_W'(c_SETTLE - 1)) begin
                r_settled <= 1'b1;
            end
        end
    end

    assign w_sum  = r_acc + r_b_q;
    assign w_diff = r_acc - r_b_q;

    always_comb begin
        w_valid  = 1'b1;
        w_ovf    = 1'b0;
        w_result = r_acc;
        case (r_op_q)
            c_OP_AND:  w_result = r_acc & r_b_q;
            c_OP_OR:   w_result = r_acc | r_b_q;
            c_OP_ADD: begin
                w_result = w_sum;
                w_ovf    = (r_acc[c_MSB] == r_b_q[c_MSB]) && (w_sum[c_MSB] != r_acc[c_MSB]);
            end
            c_OP_SUB: begin
                w_result = w_diff;
                w_ovf    = (r_acc[c_MSB] != r_b_q[c_MSB]) && (w_diff[c_MSB] != r_acc[c_MSB]);
            end
            c_OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(r_acc) < $signed(r_b_q))};
            c_OP_XOR:  w_result = r_acc ^ r_b_q;
            c_OP_NOR:  w_result = ~(r_acc | r_b_q);
            c_OP_NAND: w_result = ~(r_acc & r_b_q);
            default:   w_valid  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_WAIT_REL;
            r_op_q   <= '0;
            r_b_q    <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_op_err <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_btnu_d <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_btnu_d <= w_btnu_f;
            if (w_btnu_f) begin
                // Clear wins over everything; done marks only its first cycle
                r_acc    <= '0;
                r_ovf    <= 1'b0;
                r_op_err <= 1'b0;
                r_done   <= ~r_btnu_d;
                r_busy   <= 1'b0;
                r_state  <= S_WAIT_REL;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_btnd_f) begin
                            r_state <= S_LATCH;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_LATCH: begin
                        r_op_q  <= bus.alu_op_n;
                        r_b_q   <= bus.sw;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                    S_EXEC: begin
                        if (w_valid) begin
                            r_acc    <= w_result;
                            r_ovf    <= w_ovf;
                            r_op_err <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_op_err <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_WAIT_REL;
                    end
                    S_WAIT_REL: begin
                        if (r_settled && !w_btnd_f) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_WAIT_REL;
                    end
                endcase
            end
        end
    end

    assign bus.led    = r_acc;
    assign bus.ovf    = r_ovf;
    assign bus.op_err = r_op_err;
    assign bus.done   = r_done;
    assign bus.busy   = r_busy;

endmodule

`default_nettype wire

// File: doc/calc_exec_fsm.md
Name: calc_exec_fsm

Overview:
- Execution stage directly downstream of the button-to-opcode decoder.
- Samples the 4-bit ALU opcode and the 16 slide switches on a btnd press.
- Applies the opcode to an internal signed accumulator (acc OP sw) and drives the result to the LEDs with status flags.
- Owns button synchronisation, press/release sequencing, and accumulator clear.

Parameters:
- WIDTH, 16, accumulator/operand/LED width; two's complement.
- SYNC_STAGES, 2, flip-flop synchroniser depth on btnd and btnu; minimum 2.
- DEBOUNCE_CYCLES, 1000000, stable-level count for the debounce filter; used only with CALC_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_op_n  in  4  opcode from the decoder; asynchronous to press timing, sampled in LATCH.
- sw  in  WIDTH  operand B, sampled in LATCH.
- btnd  in  1  raw execute button, active-high.
- btnu  in  1  raw clear button, active-high.
- led  out  WIDTH  accumulator value.
- ovf  out  1  signed overflow of the last executed ADD/SUB.
- op_err  out  1  last press carried an unsupported opcode.
- done  out  1  one-cycle pulse after each accumulator write (valid op or clear).
- busy  out  1  high in LATCH and EXEC.

Behaviour:
- Reset (rst_n=0, async):
  - led=0, ovf=0, op_err=0, done=0, busy=0.
  - Synchroniser flops = 0; state = WAIT_REL.
  - A button held through reset release therefore never executes.
- Synchronisation: btnd and btnu each pass through SYNC_STAGES flops, giving btnd_s and btnu_s. No logic uses the raw inputs.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
  - 0111 SLT: acc = 1 if acc < sw (signed), else 0.
  - 1001 XOR; 1010 NOR; 1101 NAND.
  - All other codes are invalid.
- States: IDLE, LATCH, EXEC, WAIT_REL.
  - IDLE: when btnd_s=1, go to LATCH.
  - LATCH: capture op_q <- alu_op_n and b_q <- sw; go to EXEC.
  - EXEC, valid op: acc <- acc OP b_q; done=1 next cycle; op_err <- 0.
  - EXEC, ADD/SUB: ovf <- signed overflow (operand signs agree and result sign differs, with B negated for SUB).
  - EXEC, other valid ops: ovf <- 0.
  - EXEC, invalid op: acc and ovf unchanged, op_err <- 1, done not pulsed.
  - EXEC always goes to WAIT_REL.
  - WAIT_REL: when btnd_s=0, go to IDLE. One execution per press.
- Arithmetic: WIDTH-bit wrap-around; no saturation. Result truncated to WIDTH bits.
- Latency: if btnd is first sampled high at edge N (SYNC_STAGES=2), LATCH is entered at N+2, EXEC at N+3, and led updates at N+4. done is high in the cycle following N+4.
- Clear: btnu_s=1 in any state, including LATCH/EXEC, takes priority:
  - acc=0, ovf=0, op_err=0, done pulses, state goes to WAIT_REL.
  - Any pending operation is discarded.
  - If btnu_s and btnd_s rise in the same cycle, only the clear happens.
- While btnu_s stays high, the clear is reapplied every cycle; done pulses only on the first cycle.
- Opcode or switch changes after LATCH do not affect the in-flight operation.

Optional Feature:
- CALC_DEBOUNCE_EN defined:
  - Each synchronised button feeds a per-button counter.
  - The filtered level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle resets the counter.
  - FSM and clear logic use the filtered levels; latency grows by DEBOUNCE_CYCLES.
  - Counters and filtered levels reset to 0.
- CALC_DEBOUNCE_EN undefined: filtered level = synchronised level; no counters are synthesised.

Test Plan:
- Reset: hold btnd=1, pulse rst_n low, release -> led=0x0000, all flags 0. No execution until btnd goes 0 then 1.
- ADD: acc=0, alu_op_n=0010, sw=0x0005, press btnd at edge N -> led=0x0005 at N+4, done high one cycle, busy high at N+2..N+3.
- ADD then SUB:
  - Then sw=0x7FFC, ADD -> led=0x8001, ovf=1.
  - Then SUB (0110), sw=0x0003 -> led=0x7FFE, ovf=1.
  - Then AND (0000), sw=0xFFFF -> led=0x7FFE, ovf=0.
- SLT and logic: acc=0xFFFE, SLT (0111), sw=0x0001 -> led=0x0001; XOR (1001), sw=0x00FF -> 0x00FE; NAND (1101), sw=0x00F0 -> 0xFF0F.
- Invalid op 0011 -> led unchanged, op_err=1, no done; next valid op -> op_err=0. Changing alu_op_n during EXEC has no effect.
- Clear:
  - btnu and btnd asserted in the same cycle -> led=0, done once, no op.
  - rst_n low during EXEC -> all outputs 0 immediately.
  - With CALC_DEBOUNCE_EN and DEBOUNCE_CYCLES=4, a 3-cycle btnd glitch is ignored and a 10-cycle press executes once.
